// File: rtl/tmds_encoder_multi.sv
// Multi-lane TMDS encoder: DVI video 8b/10b with running disparity, control,
// TERC4 and guard-band symbols, with an optional extra pipeline stage.
module tmds_encoder_multi #(
    parameter int NUM_CH      = 3,
    parameter int PIPE_STAGES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic                  gb_video,
    input  logic [8*NUM_CH-1:0]   vd,
    input  logic [2*NUM_CH-1:0]   cd,
    input  logic [4*NUM_CH-1:0]   terc,
    output logic [10*NUM_CH-1:0]  tmds,
    output logic [5*NUM_CH-1:0]   disp
);

    localparam logic [1:0] MODE_CTRL  = 2'd0;
    localparam logic [1:0] MODE_VIDEO = 2'd1;
    localparam logic [1:0] MODE_TERC4 = 2'd2;
    localparam logic [1:0] MODE_GUARD = 2'd3;

    localparam logic [9:0] GB_EVEN = 10'b1011001100;
    localparam logic [9:0] GB_ODD  = 10'b0100110011;

    function automatic logic [3:0] count_ones8(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 8; k++) begin
            n = n + {3'b000, d[k]};
        end
        return n;
    endfunction

    // Transition-minimising stage: XOR or XNOR chain, bit 8 records which.
    function automatic logic [8:0] make_qm(input logic [7:0] d);
        logic [3:0] n;
        logic       sel;
        logic [8:0] q;
        n    = count_ones8(d);
        sel  = (n > 4'd4) || ((n == 4'd4) && !d[0]);
        q    = 9'd0;
        q[0] = d[0];
        for (int k = 1; k < 8; k++) begin
            q[k] = q[k-1] ^ d[k] ^ sel;
        end
        q[8] = ~sel;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4_code(input logic [3:0] t);
        logic [9:0] s;
        case (t)
            4'd0:    s = 10'b1010011100;
            4'd1:    s = 10'b1001100011;
            4'd2:    s = 10'b1011100100;
            4'd3:    s = 10'b1011100010;
            4'd4:    s = 10'b0101110001;
            4'd5:    s = 10'b0100011110;
            4'd6:    s = 10'b0110001110;
            4'd7:    s = 10'b0100111100;
            4'd8:    s = 10'b1011001100;
            4'd9:    s = 10'b0100111001;
            4'd10:   s = 10'b0110011100;
            4'd11:   s = 10'b1011000110;
            4'd12:   s = 10'b1010001110;
            4'd13:   s = 10'b1001110001;
            4'd14:   s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    logic [1:0]          s_mode;
    logic                s_gb;
    logic [2*NUM_CH-1:0] s_cd;
    logic [4*NUM_CH-1:0] s_terc;

    generate
        if (PIPE_STAGES == 2) begin : g_side_stage
            logic [1:0]          mode_q;
            logic                gb_q;
            logic [2*NUM_CH-1:0] cd_q;
            logic [4*NUM_CH-1:0] terc_q;

            // Side data is delayed alongside q_m so every lane sees a consistent symbol.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mode_q <= '0;
                    gb_q   <= 1'b0;
                    cd_q   <= '0;
                    terc_q <= '0;
                end else begin
                    mode_q <= mode;
                    gb_q   <= gb_video;
                    cd_q   <= cd;
                    terc_q <= terc;
                end
            end

            assign s_mode = mode_q;
            assign s_gb   = gb_q;
            assign s_cd   = cd_q;
            assign s_terc = terc_q;
        end else begin : g_side_direct
            assign s_mode = mode;
            assign s_gb   = gb_video;
            assign s_cd   = cd;
            assign s_terc = terc;
        end
    endgenerate

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
            localparam logic [9:0] GB_VID_SYM = (i % 2 == 0) ? GB_EVEN : GB_ODD;
            localparam bit         IS_LANE0   = (i == 0);

            logic [8:0]        qm_c;
            logic [8:0]        qm_s;
            logic [3:0]        n1_c;
            logic [3:0]        n1_s;
            logic signed [5:0] cnt;
            logic signed [5:0] diff;
            logic signed [5:0] cnt_nx;
            logic [9:0]        sym_d;
            logic [9:0]        sym_q;
            logic [4:0]        disp_d;
            logic [4:0]        disp_q;

            assign qm_c = make_qm(vd[8*i +: 8]);
            assign n1_c = count_ones8(qm_c[7:0]);

            if (PIPE_STAGES == 2) begin : g_qm_stage
                logic [8:0] qm_q;
                logic [3:0] n1_q;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        qm_q <= '0;
                        n1_q <= '0;
                    end else begin
                        qm_q <= qm_c;
                        n1_q <= n1_c;
                    end
                end

                assign qm_s = qm_q;
                assign n1_s = n1_q;
            end else begin : g_qm_direct
                assign qm_s = qm_c;
                assign n1_s = n1_c;
            end

            // Disparity stage: the register holding disp is also the running count.
            always_comb begin
                cnt    = {disp_q[4], disp_q};
                diff   = $signed({1'b0, n1_s, 1'b0}) - 6'sd8;
                cnt_nx = 6'sd0;
                sym_d  = 10'd0;
                case (s_mode)
                    MODE_VIDEO: begin
                        if ((cnt == 6'sd0) || (n1_s == 4'd4)) begin
                            sym_d  = {~qm_s[8], qm_s[8], qm_s[8] ? qm_s[7:0] : ~qm_s[7:0]};
                            cnt_nx = qm_s[8] ? (cnt + diff) : (cnt - diff);
                        end else if (((cnt > 6'sd0) && (n1_s > 4'd4)) ||
                                     ((cnt < 6'sd0) && (n1_s < 4'd4))) begin
                            sym_d  = {1'b1, qm_s[8], ~qm_s[7:0]};
                            cnt_nx = cnt + (qm_s[8] ? 6'sd2 : 6'sd0) - diff;
                        end else begin
                            sym_d  = {1'b0, qm_s[8], qm_s[7:0]};
                            cnt_nx = cnt - (qm_s[8] ? 6'sd0 : 6'sd2) + diff;
                        end
                    end
                    MODE_CTRL: begin
                        sym_d = ctrl_code(s_cd[2*i +: 2]);
                    end
                    MODE_TERC4: begin
                        sym_d = terc4_code(s_terc[4*i +: 4]);
                    end
                    MODE_GUARD: begin
                        if (s_gb) begin
                            sym_d = GB_VID_SYM;
                        end else if (IS_LANE0) begin
                            sym_d = terc4_code(s_terc[4*i +: 4]);
                        end else begin
                            sym_d = GB_ODD;
                        end
                    end
                    default: begin
                        sym_d = 10'd0;
                    end
                endcase
                disp_d = cnt_nx[4:0];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sym_q  <= '0;
                    disp_q <= '0;
                end else begin
                    sym_q  <= sym_d;
                    disp_q <= disp_d;
                end
            end

            assign tmds[10*i +: 10] = sym_q;
            assign disp[5*i +: 5]   = disp_q;
        end
    endgenerate

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Bench for tmds_encoder_multi: one-stage and two-stage instances share stimulus
// and are compared against a symbol-level reference model.
module tb_tmds_encoder_multi;

    localparam int NCH = 3;

    logic              clk;
    logic              rst_n;
    logic [1:0]        mode;
    logic              gbVideo;
    logic [8*NCH-1:0]  vdIn;
    logic [2*NCH-1:0]  cdIn;
    logic [4*NCH-1:0]  tercIn;
    logic [10*NCH-1:0] tmds1;
    logic [5*NCH-1:0]  disp1;
    logic [10*NCH-1:0] tmds2;
    logic [5*NCH-1:0]  disp2;

    int errCount;
    int checkCount;

    logic [9:0] ctrlTab [4]  = '{10'b1101010100, 10'b0010101011,
                                 10'b0101010100, 10'b1010101011};
    logic [9:0] tercTab [16] = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                                 10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                                 10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                                 10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    localparam logic [9:0] GB_A = 10'b1011001100;
    localparam logic [9:0] GB_B = 10'b0100110011;

    int         mcnt     [NCH];
    logic [9:0] prevSym  [NCH];
    logic [4:0] prevDisp [NCH];

    tmds_encoder_multi #(.NUM_CH(NCH), .PIPE_STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .gb_video(gbVideo),
        .vd(vdIn), .cd(cdIn), .terc(tercIn), .tmds(tmds1), .disp(disp1)
    );

    tmds_encoder_multi #(.NUM_CH(NCH), .PIPE_STAGES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .gb_video(gbVideo),
        .vd(vdIn), .cd(cdIn), .terc(tercIn), .tmds(tmds2), .disp(disp2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checkCount++;
        if (got !== want) begin
            errCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, got, want);
        end
    endtask

    task automatic resetModel();
        for (int l = 0; l < NCH; l++) begin
            mcnt[l]     = 0;
            prevSym[l]  = ctrlTab[0];
            prevDisp[l] = 5'd0;
        end
    endtask

    // Reference: choose inversion from the sign of the running count, then
    // update the count by the symbol's actual ones-minus-zeros balance.
    task automatic modelLane(input int l, input logic [1:0] m, input logic g, input logic [7:0] v,
                             input logic [1:0] c, input logic [3:0] t, output logic [9:0] sym);
        int         n1v;
        int         n1;
        int         cnt;
        logic       sel;
        logic       q8;
        logic       inv;
        logic [7:0] q;
        cnt = mcnt[l];
        sym = 10'd0;
        case (m)
            2'd1: begin
                n1v  = $countones(v);
                sel  = (n1v > 4) || (n1v == 4 && v[0] == 1'b0);
                q    = 8'd0;
                q[0] = v[0];
                for (int k = 1; k < 8; k++) q[k] = q[k-1] ^ v[k] ^ sel;
                q8 = !sel;
                n1 = $countones(q);
                if (cnt == 0 || n1 == 4) inv = !q8;
                else                     inv = ((cnt > 0) == (n1 > 4));
                sym = {inv, q8, inv ? ~q : q};
                cnt = cnt + 2 * $countones(sym) - 10;
            end
            2'd0: begin sym = ctrlTab[c]; cnt = 0; end
            2'd2: begin sym = tercTab[t]; cnt = 0; end
            default: begin
                if (g)           sym = (l % 2 == 0) ? GB_A : GB_B;
                else if (l == 0) sym = tercTab[t];
                else             sym = GB_B;
                cnt = 0;
            end
        endcase
        mcnt[l] = cnt;
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic g, input logic [8*NCH-1:0] v,
                                 input logic [2*NCH-1:0] c, input logic [4*NCH-1:0] t);
        logic [9:0]        expSym  [NCH];
        logic [4:0]        expDisp [NCH];
        logic signed [4:0] d;
        mode    = m;
        gbVideo = g;
        vdIn    = v;
        cdIn    = c;
        tercIn  = t;
        for (int l = 0; l < NCH; l++) begin
            modelLane(l, m, g, v[8*l +: 8], c[2*l +: 2], t[4*l +: 4], expSym[l]);
            expDisp[l] = 5'(mcnt[l]);
        end
        @(posedge clk);
        #1;
        for (int l = 0; l < NCH; l++) begin
            checkOutput($sformatf("p1_sym%0d", l),  32'(tmds1[10*l +: 10]), 32'(expSym[l]));
            checkOutput($sformatf("p1_disp%0d", l), 32'(disp1[5*l +: 5]),   32'(expDisp[l]));
            checkOutput($sformatf("p2_sym%0d", l),  32'(tmds2[10*l +: 10]), 32'(prevSym[l]));
            checkOutput($sformatf("p2_disp%0d", l), 32'(disp2[5*l +: 5]),   32'(prevDisp[l]));
            d = disp1[5*l +: 5];
            checkOutput($sformatf("p1_range%0d", l), 32'((d >= -10 && d <= 10) ? 1 : 0), 32'd1);
            prevSym[l]  = expSym[l];
            prevDisp[l] = expDisp[l];
        end
    endtask

    initial begin
        logic [1:0] rm;
        errCount   = 0;
        checkCount = 0;
        rst_n   = 1'b0;
        mode    = 2'd0;
        gbVideo = 1'b0;
        vdIn    = '0;
        cdIn    = '0;
        tercIn  = '0;
        resetModel();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_tmds1", 32'(tmds1), 32'd0);
        checkOutput("rst_disp1", 32'(disp1), 32'd0);
        checkOutput("rst_tmds2", 32'(tmds2), 32'd0);
        checkOutput("rst_disp2", 32'(disp2), 32'd0);
        rst_n = 1'b1;

        applyStimulus(2'd1, 1'b0, 24'h000000, 6'd0, 12'd0);
        checkOutput("v0_a_sym",  32'(tmds1[9:0]), 32'(10'b0100000000));
        checkOutput("v0_a_disp", 32'(disp1[4:0]), 32'(5'b11000));
        checkOutput("p2_first",  32'(tmds2[9:0]), 32'(10'b1101010100));
        applyStimulus(2'd1, 1'b0, 24'h000000, 6'd0, 12'd0);
        checkOutput("v0_b_sym",  32'(tmds1[9:0]), 32'(10'b1111111111));
        checkOutput("v0_b_disp", 32'(disp1[4:0]), 32'(5'd2));
        applyStimulus(2'd1, 1'b0, 24'h000000, 6'd0, 12'd0);
        checkOutput("v0_c_sym",  32'(tmds1[9:0]), 32'(10'b0100000000));
        checkOutput("v0_c_disp", 32'(disp1[4:0]), 32'(5'b11010));
        applyStimulus(2'd1, 1'b0, 24'h000000, 6'd0, 12'd0);

        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_tmds1", 32'(tmds1), 32'd0);
        checkOutput("arst_disp1", 32'(disp1), 32'd0);
        checkOutput("arst_tmds2", 32'(tmds2), 32'd0);
        checkOutput("arst_disp2", 32'(disp2), 32'd0);
        resetModel();
        #2;
        rst_n = 1'b1;
        applyStimulus(2'd1, 1'b0, 24'h000000, 6'd0, 12'd0);
        checkOutput("post_rst_sym",  32'(tmds1[9:0]), 32'(10'b0100000000));
        checkOutput("post_rst_disp", 32'(disp1[4:0]), 32'(5'b11000));
        checkOutput("post_rst_p2",   32'(tmds2[9:0]), 32'(10'b1101010100));

        applyStimulus(2'd0, 1'b0, 24'h000000, 6'd0, 12'd0);
        applyStimulus(2'd1, 1'b0, 24'hFFFFFF, 6'd0, 12'd0);
        checkOutput("vff_sym",  32'(tmds1[9:0]), 32'(10'b1000000000));
        checkOutput("vff_disp", 32'(disp1[4:0]), 32'(5'b11000));
        applyStimulus(2'd0, 1'b0, 24'hFFFFFF, 6'b010101, 12'd0);
        checkOutput("ctl01_sym",  32'(tmds1[9:0]), 32'(10'b0010101011));
        checkOutput("ctl01_disp", 32'(disp1[4:0]), 32'd0);

        for (int c = 0; c < 4; c++) begin
            applyStimulus(2'd0, 1'b0, 24'(c * 37), {3{2'(c)}}, 12'd0);
        end
        for (int t = 0; t < 16; t++) begin
            applyStimulus(2'd2, 1'b0, 24'h5A5A5A, 6'd0, {3{4'(t)}});
        end
        applyStimulus(2'd3, 1'b1, 24'h123456, 6'd0, 12'h000);
        checkOutput("gbv_lane1", 32'(tmds1[19:10]), 32'(10'b0100110011));
        applyStimulus(2'd3, 1'b0, 24'h123456, 6'd0, 12'h005);
        checkOutput("gbd_lane0", 32'(tmds1[9:0]), 32'(10'b0100011110));
        applyStimulus(2'd1, 1'b0, 24'h000000, 6'd0, 12'd0);

        for (int n = 0; n < 10000; n++) begin
            rm = ($urandom_range(0, 9) < 8) ? 2'd1 : 2'($urandom_range(0, 3));
            applyStimulus(rm, 1'($urandom_range(0, 1)), 24'($urandom), 6'($urandom), 12'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/tmds_encoder_multi.md
Name: tmds_encoder_multi

Overview:
- Parametrised multi-channel TMDS encoder for the HDMI output path.
- Sits between the video timing/pixel pipeline and the 10:1 serialisers.
- Encodes NUM_CH lanes from one shared mode select.
- Supported modes: DVI video (8b/10b with running disparity), control, HDMI data-island TERC4, and video/data guard bands.
- Optional extra pipeline stage for timing closure; per-lane disparity exposed for verification.

Parameters:
- NUM_CH, 3, number of TMDS lanes encoded in parallel (1..4).
- PIPE_STAGES, 1, output latency in clocks; legal values 1 or 2.

Ports:
- clk  input  1  pixel clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  lane mode: 0 control, 1 video, 2 TERC4, 3 guard band.
- gb_video  input  1  guard band type in mode 3: 1 video GB, 0 data-island GB.
- vd  input  8*NUM_CH  video data, lane i at [8i+7:8i].
- cd  input  2*NUM_CH  control data, lane i at [2i+1:2i].
- terc  input  4*NUM_CH  TERC4 nibble, lane i at [4i+3:4i].
- tmds  output  10*NUM_CH  encoded symbols; lane i at [10i+9:10i]; bit 0 transmitted first.
- disp  output  5*NUM_CH  per-lane signed running disparity after the current symbol; two's complement.

Behaviour:
- Reset: the asynchronous assert of rst_n=0 clears tmds, disp and every pipeline register to 0, including the staged mode. Deassertion is released on the next clk edge. No glitch-free requirement on tmds during reset.
- Latency:
  - PIPE_STAGES=1: inputs are sampled at edge t; tmds/disp are valid after edge t.
  - PIPE_STAGES=2: stage 1 registers q_m[8:0], N1 (ones count of q_m[7:0]), mode, gb_video, cd and terc. Stage 2 applies the disparity logic. Output is valid after edge t+1.
  - mode and all side data travel through the pipe aligned with their lane data.
- q_m (per lane): N1v = ones in vd.
  - xnor_sel = (N1v>4) or (N1v==4 and vd[0]==0).
  - q_m[0] = vd[0].
  - q_m[i] = q_m[i-1] XOR vd[i], inverted when xnor_sel, for i = 1..7.
  - q_m[8] = ~xnor_sel.
- Video mode (mode=1): diff = N1 - N0 of q_m[7:0], a signed even value in -8..8; cnt = the current disp, 5-bit signed.
  - Case cnt==0 or N1==4: tmds = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}; cnt += q_m8 ? diff : -diff.
  - Case (cnt>0 and N1>4) or (cnt<0 and N1<4): tmds = {1, q_m8, ~q_m[7:0]}; cnt = cnt + 2*q_m8 - diff.
  - Otherwise: tmds = {0, q_m8, q_m[7:0]}; cnt = cnt - 2*(~q_m8) + diff.
  - cnt stays within -10..+10 and never wraps.
- Control mode (mode=0), cd mapping:
  - 00 -> 1101010100
  - 01 -> 0010101011
  - 10 -> 0101010100
  - 11 -> 1010101011
- TERC4 mode (mode=2), literal MSB-first for terc values 0..15:
  - 1010011100, 1001100011, 1011100100, 1011100010
  - 0101110001, 0100011110, 0110001110, 0100111100
  - 1011001100, 0100111001, 0110011100, 1011000110
  - 1010001110, 1001110001, 0101100011, 1011000011
- Guard band mode (mode=3):
  - gb_video=1: lane 0 = 1011001100, lane 1 = 0100110011, lane 2 = 1011001100, lane 3 = 0100110011.
  - gb_video=0: lane 0 = TERC4 of its terc input; lanes ≥1 = 0100110011.
- Disparity outside video: any non-video symbol loads disp=0 on that lane. The first video symbol after any non-video symbol therefore starts from cnt=0.
- Lanes are independent; there are no cross-lane interactions.
- Mode changes take effect on the very next symbol with no bubble. Simultaneous mode change and data change are both honoured in the same symbol.
- Reset mid-stream: the next valid output after release is computed from cnt=0. With PIPE_STAGES=2 the first output after release is the control code for cd=00 (1101010100), because the staged registers hold zeros.

Test Plan:
- Reset, then mode=1, vd=0x00 for 3 clocks (PIPE_STAGES=1, lane 0) -> tmds 0100000000, 1111111111, 0100000000; disp -8, +2, -6.
- From disp=0, mode=1, vd=0xFF -> tmds 1000000000, disp -8. Then mode=0, cd=01 -> tmds 0010101011, disp 0.
- mode=0, sweep cd 00/01/10/11 on all 3 lanes -> 1101010100 / 0010101011 / 0101010100 / 1010101011 on every lane, disp 0.
- mode=2, sweep terc 0..15 -> the table above in order. mode=3, gb_video=1 -> lanes 1011001100 / 0100110011 / 1011001100. gb_video=0, terc lane 0 = 5 -> lanes 0100011110 / 0100110011 / 0100110011.
- PIPE_STAGES=2: repeat the first scenario -> same symbol sequence delayed by exactly one clock. The first post-reset symbol is 1101010100.
- Assert rst_n low asynchronously between edges during the vd=0x00 run -> tmds and disp go to 0 immediately. After release, vd=0x00 -> 0100000000 with disp -8. Across 10k random video pixels, |disp| never exceeds 10.
